// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl: restartable countdown controller with prescaler,
// pause/abort control, terminal-count strobe and optional auto-reload.
// Optional feature macro: DCC_DIR_EN adds a `dir` input; when it is latched
// high with the configuration, the counter counts up toward all-ones.
module down_counter_ctrl #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic             cfg_reload,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             done_ack,
`ifdef DCC_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done
);

  localparam int unsigned     PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_MAX  = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic             reload_q, reload_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             up_c;
  logic             cfg_hs_c;
  logic             tc_hit_c;
  logic             tick_c;

`ifdef DCC_DIR_EN
  logic dir_q, dir_d;

  // Direction latched with each accepted configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_q <= 1'b0;
    else        dir_q <= dir_d;
  end

  // Capture direction on the config handshake
  always_comb begin
    dir_d = dir_q;
    if (cfg_hs_c && !(abort && state_q == S_ARMED)) dir_d = dir;
  end

  assign up_c = dir_q;
`else
  assign up_c = 1'b0;
`endif

  assign cfg_hs_c = cfg_valid && cfg_ready;
  assign tc_hit_c = up_c ? (count_q == ALL_ONES) : (count_q == '0);
  assign tick_c   = (pre_q == PRE_MAX);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      load_q   <= '0;
      reload_q <= 1'b0;
      pre_q    <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      load_q   <= load_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
      tc_q     <= tc_d;
    end
  end

  // Next-state and datapath update; abort beats pause beats tick
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    load_d   = load_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    tc_d     = 1'b0;

    // An abort in ARMED discards a simultaneous config offer
    if (cfg_hs_c && !(abort && state_q == S_ARMED)) begin
      load_d   = cfg_load;
      reload_d = cfg_reload;
      count_d  = cfg_load;
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_hs_c) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (abort) begin
          state_d = S_IDLE;
          count_d = '0;
          pre_d   = '0;
        end else if (!cfg_hs_c && start) begin
          state_d = S_RUN;
          pre_d   = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          count_d = '0;
          pre_d   = '0;
        end else if (pause) begin
          state_d = S_HOLD;
        end else if (tick_c) begin
          pre_d = '0;
          if (tc_hit_c) begin
            tc_d = 1'b1;
            if (reload_q) count_d = load_q;
            else          state_d = S_DONE;
          end else if (up_c) begin
            count_d = count_q + WIDTH'(1);
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_IDLE;
          count_d = '0;
          pre_d   = '0;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
          count_d = '0;
          pre_d   = '0;
        end else if (done_ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign count     = count_q;
  assign tc_pulse  = tc_q;
  assign cfg_ready = (state_q == S_IDLE) || (state_q == S_ARMED);
  assign busy      = (state_q == S_RUN) || (state_q == S_HOLD);
  assign done      = (state_q == S_DONE);

endmodule

// File: doc/down_counter_ctrl.md
Name: down_counter_ctrl

Overview:
Synchronous controller that sequences a WIDTH-bit down-counter datapath: it accepts a configuration through a valid/ready handshake, then runs start, pause and abort control, and signals terminal count. It replaces free-running ripple counting wherever software or an upstream FSM needs a deterministic, restartable countdown with optional auto-reload. It sits between a control requester and any logic that consumes `count`, `tc_pulse` or `done`.

Parameters:
WIDTH, 4, counter width in bits (>=2)
PRESCALE, 1, clock cycles per count tick (>=1); 1 = tick every RUN cycle

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  config offered
cfg_ready  output  1  config accepted when cfg_valid&cfg_ready
cfg_load  input  WIDTH  start/reload value
cfg_reload  input  1  1 = auto-reload at terminal count
start  input  1  begin counting (sampled in ARMED)
pause  input  1  level; freezes count and prescaler while high in RUN
abort  input  1  pulse; return to IDLE from any non-IDLE state
done_ack  input  1  clears DONE
count  output  WIDTH  current counter value
busy  output  1  high in RUN or HOLD
tc_pulse  output  1  one-cycle strobe on terminal-count tick
done  output  1  high in DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, count=0, load_q=0, reload_q=0, pre_cnt=0, tc_pulse=0, done=0, busy=0, cfg_ready=1.
- The FSM states are IDLE, ARMED, RUN, HOLD and DONE. All outputs are registered except cfg_ready, busy and done, which decode from state.
- cfg_ready=1 in IDLE and ARMED only. A handshake latches load_q=cfg_load, reload_q=cfg_reload and count=cfg_load, then moves to ARMED. A handshake in ARMED overwrites the latched values.
- ARMED: start=1 moves to RUN next cycle and sets pre_cnt=0. If start and a cfg handshake occur in the same cycle, the cfg is taken and start is ignored.
- Tick: in RUN with pause=0, pre_cnt increments. A tick occurs when pre_cnt==PRESCALE-1, after which pre_cnt wraps to 0.
- RUN on a tick with count!=0: count decrements by 1.
- RUN on a tick with count==0: tc_pulse=1 for one cycle.
  - If reload_q=1: count=load_q and the FSM stays in RUN.
  - If reload_q=0: count stays 0 and the FSM moves to DONE.
- Terminal count falls on tick number L+1 after start, where L is the loaded value. L=0 gives tc on the first tick.
- Wrap-around: count never underflows. A decrement happens only when count!=0.
- pause=1 in RUN moves to HOLD next cycle. In that cycle there is no tick, no decrement and pre_cnt holds. In HOLD, pause=0 returns to RUN with pre_cnt preserved.
- Priority in RUN/HOLD: abort > pause > tick.
- abort in ARMED, RUN, HOLD or DONE: next state=IDLE, count=0, pre_cnt=0, no tc_pulse that cycle. load_q and reload_q are kept. abort in IDLE is ignored.
- DONE: done=1, count=0. done_ack=1 moves to IDLE next cycle. start is ignored in DONE.
- Latency: start to first decrement is PRESCALE cycles after entering RUN. With PRESCALE=1, count changes on the cycle after RUN entry.
- Reset asserted mid-operation forces the reset values immediately, with no tc_pulse.

Optional Feature:
- Macro: DCC_DIR_EN.
- Defined: adds input port `dir` (1 bit), sampled with the cfg handshake into dir_q.
  - dir_q=1 counts up.
  - Terminal count is count==2^WIDTH-1.
  - Reload restores load_q as in down mode.
  - In DONE, count holds all-ones.
  - dir_q resets to 0.
- Undefined: no `dir` port; down-count only, as described above.

Test Plan:
- Reset, then cfg (load=3, reload=0), start, PRESCALE=1 -> count 3,2,1,0 on successive cycles; tc_pulse on the 4th tick; done=1; done_ack -> IDLE and cfg_ready=1.
- load=2, reload=1 -> count sequence 2,1,0,2,1,0; tc_pulse every 3rd tick; never enters DONE.
- PRESCALE=4, load=1 -> decrement 4 cycles after RUN entry; tc_pulse 8 cycles after RUN entry.
- pause asserted for 5 cycles when count=2 -> count holds 2 and busy=1 throughout; after release, the remaining ticks complete with the prescaler phase preserved.
- abort in the same cycle as a terminal tick (count=0) -> no tc_pulse; state IDLE; count=0. Separately, rst_n=0 mid-RUN -> all outputs at reset values immediately.
- load=0, reload=0 -> tc_pulse on the first tick then DONE. With DCC_DIR_EN, dir=1 and load=13 (WIDTH=4) -> 13,14,15, then tc and DONE with count=15.
